// File: rtl/ir_pkg.sv
// Shared NEC IR types: decoder FSM states, pulse-width windows in ticks, and Snake key codes.
package ir_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStopMark,
        StRptMark,
        StErr
    } state_t;

    localparam logic [7:0] LeadMarkMin  = 8'd144;
    localparam logic [7:0] LeadMarkMax  = 8'd176;
    localparam logic [7:0] DataSpaceMin = 8'd72;
    localparam logic [7:0] DataSpaceMax = 8'd88;
    localparam logic [7:0] RptSpaceMin  = 8'd36;
    localparam logic [7:0] RptSpaceMax  = 8'd44;
    localparam logic [7:0] BitMarkMin   = 8'd7;
    localparam logic [7:0] BitMarkMax   = 8'd14;
    localparam logic [7:0] ZeroSpaceMin = 8'd7;
    localparam logic [7:0] ZeroSpaceMax = 8'd14;
    localparam logic [7:0] OneSpaceMin  = 8'd25;
    localparam logic [7:0] OneSpaceMax  = 8'd35;
    localparam logic [7:0] ErrIdleTicks = 8'd80;
    localparam logic [7:0] WidthSat     = 8'hFF;

    localparam logic [31:0] KeyUp    = 32'h20DF6A95;
    localparam logic [31:0] KeyDown  = 32'h20DFEA15;
    localparam logic [31:0] KeyLeft  = 32'h20DF1AE5;
    localparam logic [31:0] KeyRight = 32'h20DF9A65;

    function automatic logic in_win(input logic [7:0] w, input logic [7:0] lo,
                                    input logic [7:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    // Address and command bytes must each be followed by their bitwise inverse.
    function automatic logic inv_ok(input logic [31:0] f);
        return (f[31:24] == ~f[23:16]) && (f[15:8] == ~f[7:0]);
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Free-running divider producing a registered 1-clk tick every CLK_HZ/TICK_HZ clocks.
module ir_tick_gen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 17_778
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned Div = (CLK_HZ / TICK_HZ < 2) ? 2 : CLK_HZ / TICK_HZ;
    localparam int unsigned Cw  = $clog2(Div);

    logic [Cw-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == Cw'(Div - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + Cw'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: synchronizer, glitch filter, tick-based width counter and a checked
// frame/repeat FSM that holds the last valid 32-bit frame.
module nec_ir_decoder
    import ir_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 17_778,
    parameter int unsigned GLITCH_CYC = 16,
    parameter bit          CHECK_INV  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ir_signal,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        repeat_pulse,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned Gw = $clog2(GLITCH_CYC + 1);

    logic          sync1, sync2;
    logic          filt, filt_prev;
    logic [Gw-1:0] gcnt;
    logic          tick;
    logic [7:0]    wcnt;
    logic          edge_any, edge_fall, edge_rise;
    logic          lead_ok, data_ok, rpt_ok, mark_ok, zero_ok, one_ok;
    logic          sat, active, bad_edge, to_err;
    state_t        state;
    logic [5:0]    bit_cnt;
    logic [31:0]   shreg;

    ir_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    // Line idles high, so the synchronizer and filter start high to avoid a phantom edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= ir_signal;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt      <= 1'b1;
            filt_prev <= 1'b1;
            gcnt      <= '0;
        end else begin
            filt_prev <= filt;
            if (sync2 == filt) begin
                gcnt <= '0;
            end else if (gcnt == Gw'(GLITCH_CYC - 1)) begin
                filt <= sync2;
                gcnt <= '0;
            end else begin
                gcnt <= gcnt + Gw'(1);
            end
        end
    end

    assign edge_any  = filt ^ filt_prev;
    assign edge_fall = edge_any & ~filt;
    assign edge_rise = edge_any & filt;

    // An edge always sees the pre-tick count because wcnt is only ever read as a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt <= '0;
        end else if (edge_any) begin
            wcnt <= '0;
        end else if (tick && (wcnt != WidthSat)) begin
            wcnt <= wcnt + 8'd1;
        end
    end

    assign sat     = (wcnt == WidthSat);
    assign lead_ok = in_win(wcnt, LeadMarkMin, LeadMarkMax);
    assign data_ok = in_win(wcnt, DataSpaceMin, DataSpaceMax);
    assign rpt_ok  = in_win(wcnt, RptSpaceMin, RptSpaceMax);
    assign mark_ok = in_win(wcnt, BitMarkMin, BitMarkMax);
    assign zero_ok = in_win(wcnt, ZeroSpaceMin, ZeroSpaceMax);
    assign one_ok  = in_win(wcnt, OneSpaceMin, OneSpaceMax);
    assign active  = (state != StIdle) && (state != StErr);

    always_comb begin
        bad_edge = 1'b0;
        case (state)
            StLeadMark:                       bad_edge = edge_any && !lead_ok;
            StLeadSpace:                      bad_edge = edge_any && !data_ok && !rpt_ok;
            StBitMark, StStopMark, StRptMark: bad_edge = edge_any && !mark_ok;
            StBitSpace:                       bad_edge = edge_any && !zero_ok && !one_ok;
            default:                          bad_edge = 1'b0;
        endcase
    end

    assign to_err = bad_edge || (active && sat);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= StIdle;
            bit_cnt      <= '0;
            shreg        <= '0;
            word         <= '0;
            word_valid   <= 1'b0;
            repeat_pulse <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            word_valid   <= 1'b0;
            repeat_pulse <= 1'b0;
            frame_err    <= 1'b0;
            if (to_err) begin
                state     <= StErr;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    StIdle: begin
                        if (edge_fall) state <= StLeadMark;
                    end
                    StLeadMark: begin
                        if (edge_rise) state <= StLeadSpace;
                    end
                    StLeadSpace: begin
                        if (edge_fall) begin
                            if (data_ok) begin
                                state   <= StBitMark;
                                bit_cnt <= '0;
                                shreg   <= '0;
                            end else begin
                                state <= StRptMark;
                            end
                        end
                    end
                    StBitMark: begin
                        if (edge_rise) state <= StBitSpace;
                    end
                    StBitSpace: begin
                        if (edge_fall) begin
                            shreg   <= {shreg[30:0], one_ok};
                            bit_cnt <= bit_cnt + 6'd1;
                            state   <= (bit_cnt == 6'd31) ? StStopMark : StBitMark;
                        end
                    end
                    StStopMark: begin
                        if (edge_rise) begin
                            if (!CHECK_INV || inv_ok(shreg)) begin
                                word       <= shreg;
                                word_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= StIdle;
                        end
                    end
                    StRptMark: begin
                        if (edge_rise) begin
                            repeat_pulse <= 1'b1;
                            state        <= StIdle;
                        end
                    end
                    StErr: begin
                        if (filt && !edge_any && (wcnt >= ErrIdleTicks)) state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Scoreboard bench: two decoders (inverse check on/off) share one IR line; expected events are
// queued by the stimulus and popped by a monitor whenever a decoder pulses an output.
module tb_nec_ir_decoder;
    import ir_pkg::*;

    localparam int          Div     = 4;
    localparam int unsigned TickHz  = 17_778;
    localparam int unsigned ClkHz   = TickHz * Div;

    typedef struct {
        int          kind;  // 0 word_valid, 1 repeat_pulse, 2 frame_err
        logic [31:0] w;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ir;
    logic [31:0] word1, word2;
    logic        wv1, rp1, fe1, busy1;
    logic        wv2, rp2, fe2, busy2;

    ev_t         q1[$];
    ev_t         q2[$];
    logic [31:0] hw1 = '0;
    logic [31:0] hw2 = '0;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    nec_ir_decoder #(
        .CLK_HZ    (ClkHz),
        .TICK_HZ   (TickHz),
        .GLITCH_CYC(16),
        .CHECK_INV (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (rst_n),
        .ir_signal   (ir),
        .word        (word1),
        .word_valid  (wv1),
        .repeat_pulse(rp1),
        .frame_err   (fe1),
        .busy        (busy1)
    );

    nec_ir_decoder #(
        .CLK_HZ    (ClkHz),
        .TICK_HZ   (TickHz),
        .GLITCH_CYC(16),
        .CHECK_INV (1'b0)
    ) dut_ni (
        .clk         (clk),
        .reset_n     (rst_n),
        .ir_signal   (ir),
        .word        (word2),
        .word_valid  (wv2),
        .repeat_pulse(rp2),
        .frame_err   (fe2),
        .busy        (busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k1, input int k2, input logic [31:0] f);
        ev_t e;
        if (k1 == 0) hw1 = f;
        if (k2 == 0) hw2 = f;
        e.kind = k1; e.w = hw1; q1.push_back(e);
        e.kind = k2; e.w = hw2; q2.push_back(e);
    endtask

    task automatic mon(input int id, input logic v, input logic r, input logic e,
                       input logic [31:0] w);
        ev_t x;
        int  kind;
        if (v || r || e) begin
            chk($sformatf("dut%0d onehot", id), 32'($countones({v, r, e})), 32'd1);
            kind = v ? 0 : (r ? 1 : 2);
            if ((id == 1 && q1.size() == 0) || (id == 2 && q2.size() == 0)) begin
                checks++;
                errs++;
                $display("FAIL dut%0d unexpected: got kind %0d word %h expected no event",
                         id, kind, w);
            end else begin
                x = (id == 1) ? q1.pop_front() : q2.pop_front();
                chk($sformatf("dut%0d kind", id), 32'(kind), 32'(x.kind));
                chk($sformatf("dut%0d word", id), w, x.w);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1, wv1, rp1, fe1, word1);
            mon(2, wv2, rp2, fe2, word2);
        end
    end

    task automatic hold(input logic lvl, input int ticks);
        ir = lvl;
        repeat (ticks * Div) @(negedge clk);
    endtask

    // 8-clk low glitch shortly after the space starts; shorter than the 16-clk filter.
    task automatic space_glitch(input int ticks);
        ir = 1'b1;
        repeat (16) @(negedge clk);
        ir = 1'b0;
        repeat (8) @(negedge clk);
        ir = 1'b1;
        repeat (ticks * Div - 24) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] f, input int nbits, input bit glitch);
        for (int i = 31; i > 31 - nbits; i--) begin
            hold(1'b0, 10);
            if (glitch) space_glitch(f[i] ? 30 : 10);
            else        hold(1'b1, f[i] ? 30 : 10);
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input bit glitch);
        hold(1'b0, 160);
        hold(1'b1, 80);
        send_bits(f, 32, glitch);
        hold(1'b0, 10);
        hold(1'b1, 100);
    endtask

    task automatic check_idle(input string name);
        chk({name, " busy"}, {30'd0, busy1, busy2}, 32'd0);
        chk({name, " word1"}, word1, hw1);
        chk({name, " word2"}, word2, hw2);
    endtask

    initial begin
        ir    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset word", word1, 32'd0);
        chk("reset flags", {28'd0, busy1, wv1, rp1, fe1}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 20);

        expect_ev(0, 0, KeyUp);
        send_frame(KeyUp, 1'b0);
        check_idle("up");

        expect_ev(1, 1, 32'd0);
        hold(1'b0, 160);
        hold(1'b1, 40);
        hold(1'b0, 10);
        hold(1'b1, 100);
        check_idle("repeat");

        expect_ev(2, 0, 32'h20DF6A96);
        send_frame(32'h20DF6A96, 1'b0);
        check_idle("inv");

        expect_ev(0, 0, KeyRight);
        send_frame(KeyRight, 1'b1);
        check_idle("glitch");

        expect_ev(2, 2, 32'd0);
        hold(1'b0, 124);
        hold(1'b1, 120);
        check_idle("short lead");

        expect_ev(2, 2, 32'd0);
        hold(1'b0, 160);
        hold(1'b1, 80);
        send_bits(KeyDown, 5, 1'b0);
        hold(1'b0, 355);
        hold(1'b1, 120);
        check_idle("stuck");

        expect_ev(0, 0, KeyDown);
        send_frame(KeyDown, 1'b0);
        check_idle("down");

        hold(1'b0, 160);
        hold(1'b1, 80);
        send_bits(KeyLeft, 17, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset word1", word1, 32'd0);
        chk("midreset word2", word2, 32'd0);
        chk("midreset flags", {24'd0, busy1, wv1, rp1, fe1, busy2, wv2, rp2, fe2}, 32'd0);
        hw1 = '0;
        hw2 = '0;
        hold(1'b1, 5);
        rst_n = 1'b1;
        hold(1'b1, 20);

        expect_ev(0, 0, KeyLeft);
        send_frame(KeyLeft, 1'b0);
        check_idle("left");

        repeat (100) @(negedge clk);
        chk("q1 drained", 32'(q1.size()), 32'd0);
        chk("q2 drained", 32'(q2.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
